vpi_stim_fifo: RTL and testbench
================================

Name: vpi_stim_fifo

Overview:
- Stimulus queue between a VPI/DPI test harness and the design under test.
- The harness writes words into VPI-writable registers; the block buffers them in a circular FIFO.
- Buffered words are presented downstream on a valid/ready stream, e.g. to a compare stage that checks sig against rfr.
- Dropped writes and occupancy are counted so the C side can read back status through public read-only signals.

Parameters:
- WIDTH, 32, data word width in bits (1..512).
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1, width of occupancy and high-water signals; derived, do not override.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- push  input  1  write strobe; one word offered per cycle while high.
- push_data  input  WIDTH  word captured when push is accepted.
- full  output  1  high when count==DEPTH.
- out_valid  output  1  head entry available.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  WIDTH  head entry; stable while out_valid && !out_ready.
- count  output  CW  current occupancy, 0..DEPTH.
- drop_cnt  output  8  number of rejected pushes; saturates at 255.
- hwm  output  CW  occupancy high-water mark (see Optional Feature).

Behaviour:
- Interface: push, push_data and out_ready are written by the VPI harness on posedge clk. count, drop_cnt and hwm are publicly readable.
- Reset (reset=1 at posedge):
  - rd_ptr, wr_ptr, count, drop_cnt and hwm go to 0.
  - Outputs: full=0, out_valid=0, out_data=0.
  - Memory contents are not cleared.
  - Reset has priority over push and pop in the same cycle.
  - Reset mid-stream discards all queued entries; no pop is reported.
- Storage: DEPTH x WIDTH array. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Pop: when out_valid && out_ready at posedge:
  - rd_ptr increments.
  - count decrements unless a simultaneous push is accepted.
- Push acceptance: accepted iff push && (!full || pop this cycle).
  - If full and popping in the same cycle, the push is accepted and count stays at DEPTH.
  - On accept: mem[wr_ptr] <= push_data and wr_ptr increments.
- Drop: push && full && !pop leaves the FIFO unchanged and increments drop_cnt, saturating at 255.
- Simultaneous push+pop, not full: count unchanged; both pointers advance.
- Pop when empty: out_valid=0, so out_ready is ignored and there is no underflow.
- Output timing:
  - out_valid = (count!=0) and out_data = mem[rd_ptr], both taken from registered state only, with no combinational path from push.
  - Latency: a word pushed at posedge N is visible on out_valid/out_data after posedge N (first-fall-through, one cycle).
  - When out_valid=0, out_data is 0 (masked), so the C side reads deterministic values.
  - Ordering is strict FIFO.
- Derived signals:
  - full = (count==DEPTH).
  - count is a registered counter, not pointer-derived.
- There is no state machine beyond the counters. The block is fully synchronous with no latches.

Optional Feature:
- Macro: VPI_STIM_FIFO_HWM_EN.
- Defined:
  - hwm is a CW-bit register, 0 on reset.
  - Each cycle, if next count > hwm, then hwm <= next count.
  - hwm never decreases except on reset.
- Undefined: hwm is tied to 0 and no register is inferred. The port always exists so the harness compiles either way.

Test Plan:
- Reset then single push: reset 2 cycles; push 0xDEADBEEF for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=0xDEADBEEF, count=1, full=0.
- Fill and drop: DEPTH=4, push 0x1..0x6 on consecutive cycles with out_ready=0 -> full=1 after the 4th push, count=4, drop_cnt=2; drain yields 0x1,0x2,0x3,0x4 in order, then out_valid=0, out_data=0.
- Full with simultaneous push+pop: count=4 holding 0xA..0xD; push 0xE with out_ready=1 -> 0xA popped, count stays 4, drop_cnt unchanged; drain yields 0xB,0xC,0xD,0xE.
- Wrap-around: 10 push/pop cycles with out_ready=1 continuously, data 0..9 -> outputs 0..9 in order, each one cycle after its push, count never exceeds 1, pointers wrap twice.
- Reset mid-operation: 3 entries queued, assert reset for 1 cycle together with push=1 -> count=0, out_valid=0, drop_cnt=0; the pushed word is not stored.
- Drop saturation and HWM: 300 pushes while full -> drop_cnt=255. With VPI_STIM_FIFO_HWM_EN, after a peak of 3 then drain -> hwm=3; without the macro -> hwm=0.

Source files
------------

// File: rtl/vpi_stim_fifo.sv
// Stimulus FIFO between a VPI/DPI harness and the DUT, with drop counter and status.
// Define VPI_STIM_FIFO_HWM_EN to enable the occupancy high-water mark register.
module vpi_stim_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [7:0]       drop_cnt,
    output logic [CW-1:0]    hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic [7:0]       drop_q;
    logic             pop;
    logic             push_acc;
    logic             drop;

    assign full      = (count_q == CNT_FULL);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push_acc  = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        count_nxt = count_q;
        if (push_acc && !pop)
            count_nxt = count_q + CNT_ONE;
        else if (pop && !push_acc)
            count_nxt = count_q - CNT_ONE;
    end

    // Storage is deliberately left uncleared by reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && push_acc)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            count_q <= count_nxt;
            if (drop && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end

`ifdef VPI_STIM_FIFO_HWM_EN
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (reset)
            hwm_q <= '0;
        else if (count_nxt > hwm_q)
            hwm_q <= count_nxt;
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_vpi_stim_fifo.sv
// Directed self-checking bench for vpi_stim_fifo (DEPTH=4, WIDTH=32).
module tb_vpi_stim_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef VPI_STIM_FIFO_HWM_EN
    localparam int HWM_ON = 1;
`else
    localparam int HWM_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             full;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic [7:0]       drop_cnt;
    logic [CW-1:0]    hwm;

    int vectors    = 0;
    int miscompares = 0;

    vpi_stim_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .hwm       (hwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs changed after this return are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; push_data = '0; out_ready = 1'b0;
        step();
        step();
        check("rst_count", 64'(count), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_full", 64'(full), 0);
        check("rst_data", 64'(out_data), 0);
        check("rst_drop", 64'(drop_cnt), 0);
        check("rst_hwm", 64'(hwm), 0);
        reset = 1'b0;

        // single push, one-cycle fall-through
        push = 1'b1; push_data = 32'hDEADBEEF;
        step();
        push = 1'b0;
        check("single_valid", 64'(out_valid), 1);
        check("single_data", 64'(out_data), 64'hDEADBEEF);
        check("single_count", 64'(count), 1);
        check("single_full", 64'(full), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_drained", 64'(out_valid), 0);

        // fill past capacity, two drops
        for (int i = 1; i <= 6; i++) begin
            push = 1'b1; push_data = WIDTH'(i);
            step();
            if (i == 4) begin
                check("fill_full", 64'(full), 1);
                check("fill_count", 64'(count), 4);
            end
        end
        push = 1'b0;
        check("fill_drop", 64'(drop_cnt), 2);
        check("fill_count_after", 64'(count), 4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 64'(out_valid), 1);
            check("drain_data", 64'(out_data), 64'(i));
            step();
        end
        check("drain_empty", 64'(out_valid), 0);
        check("drain_mask", 64'(out_data), 0);
        check("drain_count", 64'(count), 0);
        out_ready = 1'b0;

        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = WIDTH'(32'hA + i);
            step();
        end
        check("pp_head", 64'(out_data), 64'hA);
        push_data = 32'hE; out_ready = 1'b1;
        step();
        push = 1'b0;
        check("pp_count", 64'(count), 4);
        check("pp_full", 64'(full), 1);
        check("pp_drop", 64'(drop_cnt), 2);
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", 64'(out_data), 64'(32'hB + i));
            step();
        end
        check("pp_empty", 64'(out_valid), 0);

        // streaming through wrap-around
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; push_data = WIDTH'(i);
            step();
            check("wrap_data", 64'(out_data), 64'(i));
            check("wrap_count", 64'(count), 1);
        end
        push = 1'b0;
        step();
        check("wrap_empty", 64'(count), 0);
        out_ready = 1'b0;

        // reset mid-stream with concurrent push
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = WIDTH'(32'h30 + i);
            step();
        end
        check("mid_count_pre", 64'(count), 3);
        reset = 1'b1; push_data = 32'h55;
        step();
        reset = 1'b0; push = 1'b0;
        check("mid_count", 64'(count), 0);
        check("mid_valid", 64'(out_valid), 0);
        check("mid_drop", 64'(drop_cnt), 0);
        check("mid_data", 64'(out_data), 0);
        check("mid_hwm", 64'(hwm), 0);

        // peak of three then drain
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = WIDTH'(32'h77 + i);
            step();
        end
        push = 1'b0;
        check("peak_head", 64'(out_data), 64'h77);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        check("peak_empty", 64'(count), 0);
        check("peak_hwm", 64'(hwm), HWM_ON ? 3 : 0);

        // drop counter saturation
        for (int i = 0; i < 4 + 300; i++) begin
            push = 1'b1; push_data = WIDTH'(i);
            step();
            if (i == 4 + 254 - 1)
                check("sat_254", 64'(drop_cnt), 254);
        end
        push = 1'b0;
        check("sat_drop", 64'(drop_cnt), 255);
        check("sat_count", 64'(count), 4);
        check("sat_head", 64'(out_data), 0);
        check("sat_hwm", 64'(hwm), HWM_ON ? 4 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
